// File: rtl/rom_port_arbiter_if.sv
// Bundle of the two master ports and the shared slave port around rom_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding fetch/LSU/memory side.
interface rom_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_M0_REQ;
    logic [ADDR_W-1:0] i_M0_ADDR;
    logic              o_M0_GNT;
    logic [DATA_W-1:0] o_M0_RDATA;

    logic              i_M1_REQ;
    logic              i_M1_WE;
    logic [1:0]        i_M1_HB;
    logic [ADDR_W-1:0] i_M1_ADDR;
    logic [DATA_W-1:0] i_M1_WDATA;
    logic              o_M1_GNT;
    logic [DATA_W-1:0] o_M1_RDATA;

    logic              o_S_REQ;
    logic              o_S_CE;
    logic              o_S_WE;
    logic [1:0]        o_S_HB;
    logic [ADDR_W-1:0] o_S_ADDR;
    logic [DATA_W-1:0] o_S_WDATA;
    logic              i_S_GNT;
    logic [DATA_W-1:0] i_S_RDATA;

    logic              o_ERR;

    modport master (
        output i_M0_REQ, i_M0_ADDR,
        input  o_M0_GNT, o_M0_RDATA,
        output i_M1_REQ, i_M1_WE, i_M1_HB, i_M1_ADDR, i_M1_WDATA,
        input  o_M1_GNT, o_M1_RDATA,
        input  o_S_REQ, o_S_CE, o_S_WE, o_S_HB, o_S_ADDR, o_S_WDATA,
        output i_S_GNT, i_S_RDATA,
        input  o_ERR
    );

    modport slave (
        input  i_M0_REQ, i_M0_ADDR,
        output o_M0_GNT, o_M0_RDATA,
        input  i_M1_REQ, i_M1_WE, i_M1_HB, i_M1_ADDR, i_M1_WDATA,
        output o_M1_GNT, o_M1_RDATA,
        output o_S_REQ, o_S_CE, o_S_WE, o_S_HB, o_S_ADDR, o_S_WDATA,
        input  i_S_GNT, i_S_RDATA,
        output o_ERR
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Two-master (fetch, LSU) arbiter for a single REQ/GNT slave port; LSU has priority with a
// fetch starvation guard. Define ROM_ARB_TIMEOUT_EN to add the BUSY timeout and sticky o_ERR.
module rom_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    rom_port_arbiter_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              s_req_q, s_req_d;
    logic              s_we_q, s_we_d;
    logic [1:0]        s_hb_q, s_hb_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic              m0_gnt_q, m0_gnt_d;
    logic              m1_gnt_q, m1_gnt_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

    logic              m0_elig, m1_elig, pick_m0;

`ifdef ROM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
`else
    logic              unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign m0_elig = bus.i_M0_REQ & ~m0_gnt_q;
    assign m1_elig = bus.i_M1_REQ & ~m1_gnt_q;
    // LSU wins unless fetch has already lost MAX_WAIT times in a row
    assign pick_m0 = m0_elig & (~m1_elig | (wait_cnt_q == WAIT_W'(MAX_WAIT)));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wait_cnt_d = wait_cnt_q;
        s_req_d    = s_req_q;
        s_we_d     = s_we_q;
        s_hb_d     = s_hb_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m0_gnt_d   = 1'b0;
        m1_gnt_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef ROM_ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (m0_elig || m1_elig) begin
                    if (pick_m0) begin
                        owner_d    = 1'b0;
                        s_we_d     = 1'b0;
                        s_hb_d     = 2'b10;
                        s_addr_d   = bus.i_M0_ADDR;
                        s_wdata_d  = '0;
                        wait_cnt_d = '0;
                    end else begin
                        owner_d   = 1'b1;
                        s_we_d    = bus.i_M1_WE;
                        s_hb_d    = bus.i_M1_HB;
                        s_addr_d  = bus.i_M1_ADDR;
                        s_wdata_d = bus.i_M1_WDATA;
                        if (m0_elig && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end
                    s_req_d = 1'b1;
                    state_d = StBusy;
`ifdef ROM_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            StBusy: begin
                // A grant coinciding with the timeout takes precedence
                if (bus.i_S_GNT) begin
                    s_req_d = 1'b0;
                    state_d = StResp;
                    if (owner_q) begin
                        m1_gnt_d   = 1'b1;
                        m1_rdata_d = bus.i_S_RDATA;
                    end else begin
                        m0_gnt_d   = 1'b1;
                        m0_rdata_d = bus.i_S_RDATA;
                    end
                end
`ifdef ROM_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    s_req_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = StResp;
                    if (owner_q) begin
                        m1_gnt_d   = 1'b1;
                        m1_rdata_d = DATA_W'(32'hDEADBEEF);
                    end else begin
                        m0_gnt_d   = 1'b1;
                        m0_rdata_d = DATA_W'(32'hDEADBEEF);
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            wait_cnt_q <= '0;
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_hb_q     <= 2'b00;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef ROM_ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            s_req_q    <= s_req_d;
            s_we_q     <= s_we_d;
            s_hb_q     <= s_hb_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m0_gnt_q   <= m0_gnt_d;
            m1_gnt_q   <= m1_gnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef ROM_ARB_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.o_S_REQ    = s_req_q;
    assign bus.o_S_CE     = s_req_q;
    assign bus.o_S_WE     = s_we_q;
    assign bus.o_S_HB     = s_hb_q;
    assign bus.o_S_ADDR   = s_addr_q;
    assign bus.o_S_WDATA  = s_wdata_q;
    assign bus.o_M0_GNT   = m0_gnt_q;
    assign bus.o_M1_GNT   = m1_gnt_q;
    assign bus.o_M0_RDATA = m0_rdata_q;
    assign bus.o_M1_RDATA = m1_rdata_q;
`ifdef ROM_ARB_TIMEOUT_EN
    assign bus.o_ERR      = err_q;
`else
    assign bus.o_ERR      = 1'b0;
`endif
endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single data-side request/grant port of the boot ROM (or any slave with the same REQ/GNT protocol) between two masters.
- Master 0 is the instruction fetch unit; master 1 is the load/store unit.
- Sits between the core's fetch/LSU and the memory slave. Sequences one outstanding transaction at a time with a small FSM.
- Data accesses have priority, with starvation protection for fetch.

Parameters:
- ADDR_W, 32, address width of masters and slave.
- DATA_W, 32, read/write data width.
- MAX_WAIT, 4, number of consecutive master-1 wins allowed while master 0 is pending before master 0 is forced.
- TIMEOUT, 16, cycles in BUSY without slave grant before abort (used only with the optional feature).

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  reset
- i_M0_REQ  in  1  fetch request; held high until o_M0_GNT
- i_M0_ADDR  in  ADDR_W  fetch byte address
- o_M0_GNT  out  1  one-cycle completion pulse for master 0
- o_M0_RDATA  out  DATA_W  fetch read data, valid with o_M0_GNT
- i_M1_REQ  in  1  data request; held high until o_M1_GNT
- i_M1_WE  in  1  write enable (1=write)
- i_M1_HB  in  2  size: 00 byte, 01 half, others word
- i_M1_ADDR  in  ADDR_W  data byte address
- i_M1_WDATA  in  DATA_W  write data
- o_M1_GNT  out  1  one-cycle completion pulse for master 1
- o_M1_RDATA  out  DATA_W  data read data, valid with o_M1_GNT
- o_S_REQ  out  1  slave request, held until i_S_GNT
- o_S_CE  out  1  slave chip enable, equals o_S_REQ
- o_S_WE  out  1  slave write enable
- o_S_HB  out  2  slave size; fetch always drives 2'b10
- o_S_ADDR  out  ADDR_W  slave address
- o_S_WDATA  out  DATA_W  slave write data
- i_S_GNT  in  1  slave completion, data valid same cycle
- i_S_RDATA  in  DATA_W  slave read data
- o_ERR  out  1  sticky timeout flag (present only with the optional feature, tied 0 otherwise)

Behaviour:
- Reset: i_RSTn is synchronous and active-low on i_CLK. While asserted:
  - FSM goes to IDLE.
  - All outputs go to 0, including both RDATA outputs and o_ERR.
  - wait_cnt and the timeout counter clear.
  - A transaction in flight is dropped and no GNT is issued for it.
- FSM states: IDLE, BUSY (owner register: 0 or 1), RESP.
- IDLE:
  - Eligible requesters are i_Mx_REQ & ~o_Mx_GNT, which masks the master being granted this cycle.
  - If both are eligible and wait_cnt == MAX_WAIT, M0 wins. Otherwise, if M1 is eligible, M1 wins; else M0.
  - On a win, the winner's addr/we/hb/wdata are latched into slave registers, o_S_REQ goes to 1 next cycle, and the FSM enters BUSY.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when M1 wins while M0 is eligible.
  - Clears when M0 wins.
  - Width is $clog2(MAX_WAIT+1).
- BUSY:
  - o_S_* stay stable from the latched registers.
  - On i_S_GNT=1: capture i_S_RDATA into the owner's RDATA register, drop o_S_REQ and o_S_CE next cycle, assert the owner's o_Mx_GNT for exactly the next cycle, and go to RESP.
  - On writes, RDATA is still captured (the slave returns don't-care data).
- RESP: one cycle, during which the GNT pulse is visible. Then return to IDLE.
- Latency: request sampled at edge k → o_S_REQ high in cycle k+1. With a slave granting one cycle later, o_Mx_GNT is high in cycle k+3. Issue rate is at most 1 transaction per 4 cycles.
- A master dropping REQ while it owns BUSY does not cancel the transaction; its GNT still pulses.
- A master changing ADDR while BUSY has no effect, because the address is latched.
- o_Mx_RDATA holds its value until that master's next grant. A grant to the other master does not disturb it.
- No request is accepted during BUSY or RESP. Requests simply wait.

Optional Feature:
- Macro: ROM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY.
  - If it reaches TIMEOUT with no i_S_GNT: drop o_S_REQ, pulse the owner's GNT with RDATA = 32'hDEADBEEF, set o_ERR (sticky until reset), and go to RESP.
  - The counter clears on entering BUSY.
  - If i_S_GNT arrives in the same cycle as the timeout, the grant wins and o_ERR is not set.
- Undefined: no counter, o_ERR tied 0, and BUSY waits indefinitely.

Test Plan:
- M0 alone, addr 0x10, slave returns 0x12345678 one cycle after REQ → o_S_ADDR=0x10, o_S_HB=2'b10; o_M0_GNT is a single pulse 3 cycles after the request edge with o_M0_RDATA=0x12345678.
- M0 and M1 request in the same cycle (M0 0x0, M1 0x20) → M1 is served first, then M0. Each GNT is a single pulse, and o_M0_RDATA is unchanged by M1's grant.
- M1 requests continuously and M0 is held high, MAX_WAIT=4 → after 4 M1 grants the 5th slave transaction has o_S_ADDR equal to the M0 address.
- Reset asserted in BUSY with o_S_REQ=1 → next cycle o_S_REQ=0, no GNT pulses, and after release a new request is served normally.
- M1 write, WE=1, HB=2'b00, addr 0x3, wdata 0xAB → o_S_WE=1, o_S_HB=00, o_S_ADDR=0x3 and o_S_WDATA=0xAB stable until i_S_GNT.
- With ROM_ARB_TIMEOUT_EN and TIMEOUT=16, slave never grants → o_M0_GNT pulses with 0xDEADBEEF after 16 BUSY cycles, o_ERR=1 and stays 1.
